escalonador_tiros: RTL
======================

// Module: escalonador_tiros
// PURPOSE
// - Owns a pool of N_SLOTS projectile slots shared by two requesters: player (fires up) and enemy (fires down).
// - Arbitrates fire requests, allocates free slots, advances every active projectile on a divided game tick.
// - Frees slots on screen exit or collision. Feeds per-slot x/y/active to the renderer and collision logic.
// PARAMETERS
// - N_SLOTS   4      number of projectile slots (2..8)
// - TICK_DIV  50000  CLOCK_50 cycles per movement tick
// - Y_MAX     480    first off-screen row
// - OFFSET    35     vertical spawn distance from shooter origin
// PORTS
// - CLOCK_50      in   1            system clock; all state on posedge
// - reset         in   1            async, active-high; clears all state
// - pausa         in   1            1 = freeze movement, tick counter and grants
// - req_jogador   in   1            player fire request, held until ack_jogador
// - x_jogador     in   10           player spawn x
// - y_jogador     in   10           player spawn y origin
// - req_inimigo   in   1            enemy fire request, held until ack_inimigo
// - x_inimigo     in   10           enemy spawn x
// - y_inimigo     in   10           enemy spawn y origin
// - acerto        in   N_SLOTS      per-slot hit; frees slot at next edge
// - ack_jogador   out  1            1-cycle grant pulse, registered
// - ack_inimigo   out  1            1-cycle grant pulse, registered
// - ativo         out  N_SLOTS      slot occupied
// - sentido       out  N_SLOTS      1 = moving up (player), 0 = down (enemy)
// - x_tiros       out  10*N_SLOTS   slot i x at [10*i+9:10*i]
// - y_tiros       out  10*N_SLOTS   slot i y at [10*i+9:10*i]
// BEHAVIOUR
// - Reset: ativo=0, sentido=0, x_tiros=y_tiros=0, acks=0, tick counter=0, round-robin pointer=player.
// - Tick: counter 0..TICK_DIV-1; tick=1 for the one cycle counter==TICK_DIV-1, then wraps to 0. Holds while pausa=1.
// - Grant eligibility: pausa=0, req high, own ack low this cycle (no double grant), and a free slot exists.
// - Arbitration: one grant per cycle; if both eligible, pointer side wins and pointer flips to the other side.
//   Single eligible requester wins without moving the pointer.
// - Allocation: lowest-index slot with ativo=0 in the current state; slot and ack update on the same edge.
//   Latency: req sampled at edge k -> ativo/x/y valid and ack high during cycle k..k+1.
// - Spawn player: x=x_jogador, y=y_jogador-OFFSET saturated at 0, sentido=1.
//   Spawn enemy: x=x_inimigo, y=min(y_inimigo+OFFSET, Y_MAX-1), sentido=0.
// - Movement on tick, pausa=0, per active slot:
//   - up with y==0 -> freed
//   - else y-1
//   - down with y>=Y_MAX-1 -> freed
//   - else y+1
//   - x constant
// - Priority per slot each edge: acerto[i] (free) > movement. acerto on an inactive slot is ignored.
// - Slot freed this edge is allocatable next cycle, not the same cycle. A just-allocated slot does not move on that edge.
// - Full pool: no ack; request stays pending and is granted on the first cycle a slot is free.
// - Freed slot keeps stale x/y; consumers qualify with ativo.
// - Reset mid-operation: all projectiles dropped immediately; pending requests re-evaluated after release.
// CONFIGURATION
// - LIMITE_JOGADOR_EN defined: player eligible only when no active slot has sentido=1 (one player shot on screen).
// - LIMITE_JOGADOR_EN undefined: player may hold any number of free slots.
// - Enemy unaffected either way.
// TESTING
// - Reset, req_jogador=1, x=100, y=400 -> slot0 ativo, x=100, y=365, sentido=1, ack_jogador 1 cycle.
// - TICK_DIV=4, enemy shot at y=478 -> y=479 after 1 tick, freed on next tick.
//   Player shot at y=0 -> freed on next tick.
// - Both req every cycle, N_SLOTS=4 -> grants alternate J,I,J,I into slots 0..3; 5th request waits.
//   acerto[2] pulse -> slot2 granted the cycle after.
// - pausa=1 for 10 ticks with 2 active shots -> y unchanged, no acks; resume -> motion continues.
// - LIMITE_JOGADOR_EN: second player req while player shot active -> no ack until that shot frees.
//   Undefined -> immediate ack.
// - reset pulse with 3 active slots mid-tick -> ativo=0 and counter=0 asynchronously.

Source files
------------

// File: rtl/escalonador_tiros_if.sv
// Bundle between the projectile scheduler and the game logic that requests shots.
// The master side is the game (requesters, hit detector); the slave side is escalonador_tiros.
interface escalonador_tiros_if #(
  parameter int N_SLOTS  = 4,
  parameter int TICK_DIV = 50000
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Handshake: a requester raises req and holds it with stable x/y until it sees a
  // one-cycle ack; the slot is already loaded during the cycle ack is high.
  logic                   pausa;
  logic                   req_jogador;
  logic [9:0]             x_jogador;
  logic [9:0]             y_jogador;
  logic                   req_inimigo;
  logic [9:0]             x_inimigo;
  logic [9:0]             y_inimigo;
  logic [N_SLOTS-1:0]     acerto;
  logic                   ack_jogador;
  logic                   ack_inimigo;
  logic [N_SLOTS-1:0]     ativo;
  logic [N_SLOTS-1:0]     sentido;
  logic [10*N_SLOTS-1:0]  x_tiros;
  logic [10*N_SLOTS-1:0]  y_tiros;
  logic [CW-1:0]          dbg_contador;
  logic                   dbg_ponteiro;

  modport master (
    output pausa, req_jogador, x_jogador, y_jogador,
    output req_inimigo, x_inimigo, y_inimigo, acerto,
    input  ack_jogador, ack_inimigo, ativo, sentido, x_tiros, y_tiros,
    input  dbg_contador, dbg_ponteiro
  );

  modport slave (
    input  pausa, req_jogador, x_jogador, y_jogador,
    input  req_inimigo, x_inimigo, y_inimigo, acerto,
    output ack_jogador, ack_inimigo, ativo, sentido, x_tiros, y_tiros,
    output dbg_contador, dbg_ponteiro
  );
endinterface

// File: rtl/escalonador_tiros.sv
// Projectile slot pool shared by player (up) and enemy (down) with round-robin grants.
// Define LIMITE_JOGADOR_EN to allow only one player shot on screen at a time.
module escalonador_tiros #(
  parameter int N_SLOTS  = 4,
  parameter int TICK_DIV = 50000,
  parameter int Y_MAX    = 480,
  parameter int OFFSET   = 35
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  escalonador_tiros_if.slave bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(N_SLOTS);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0]   Y_LAST    = 11'(Y_MAX - 1);
  localparam logic [10:0]   OFS       = 11'(OFFSET);

  typedef enum logic {PTR_JOGADOR = 1'b0, PTR_INIMIGO = 1'b1} ptr_t;

  logic [CW-1:0]      contador;
  ptr_t               ponteiro;
  logic               ack_j, ack_i;
  logic [N_SLOTS-1:0] ativo, sentido;
  logic [9:0]         x_r [N_SLOTS];
  logic [9:0]         y_r [N_SLOTS];

  logic               tick;
  logic               livre_ok;
  logic [SW-1:0]      livre_idx;
  logic               jogador_livre;
  logic               elig_j, elig_i, grant_j, grant_i;
  logic [10:0]        yj_ext, soma_i;
  logic [9:0]         y_spawn_j, y_spawn_i;

  assign tick = !bus.pausa && (contador == TICK_LAST);

  // Lowest-index free slot, judged on the registered state only.
  always_comb begin
    livre_ok  = 1'b0;
    livre_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!ativo[i]) begin
        livre_ok  = 1'b1;
        livre_idx = SW'(i);
      end
    end
  end

`ifdef LIMITE_JOGADOR_EN
  assign jogador_livre = ~|(ativo & sentido);
`else
  assign jogador_livre = 1'b1;
`endif

  assign elig_j  = !bus.pausa && bus.req_jogador && !ack_j && livre_ok && jogador_livre;
  assign elig_i  = !bus.pausa && bus.req_inimigo && !ack_i && livre_ok;
  assign grant_j = elig_j && (!elig_i || ponteiro == PTR_JOGADOR);
  assign grant_i = elig_i && !grant_j;

  assign yj_ext    = {1'b0, bus.y_jogador};
  assign soma_i    = {1'b0, bus.y_inimigo} + OFS;
  assign y_spawn_j = (yj_ext >= OFS) ? 10'(yj_ext - OFS) : 10'd0;
  assign y_spawn_i = (soma_i > Y_LAST) ? 10'(Y_LAST) : 10'(soma_i);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      contador <= '0;
      ponteiro <= PTR_JOGADOR;
      ack_j    <= 1'b0;
      ack_i    <= 1'b0;
      ativo    <= '0;
      sentido  <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else begin
      ack_j <= grant_j;
      ack_i <= grant_i;
      if (!bus.pausa) contador <= tick ? '0 : contador + 1'b1;
      if (elig_j && elig_i)
        ponteiro <= (ponteiro == PTR_JOGADOR) ? PTR_INIMIGO : PTR_JOGADOR;

      for (int i = 0; i < N_SLOTS; i++) begin
        if (ativo[i]) begin
          // A hit wins over movement; exiting the screen frees instead of moving.
          if (bus.acerto[i]) begin
            ativo[i] <= 1'b0;
          end else if (tick) begin
            if (sentido[i]) begin
              if (y_r[i] == 10'd0) ativo[i] <= 1'b0;
              else                 y_r[i]   <= y_r[i] - 10'd1;
            end else begin
              if ({1'b0, y_r[i]} >= Y_LAST) ativo[i] <= 1'b0;
              else                          y_r[i]   <= y_r[i] + 10'd1;
            end
          end
        end else if ((grant_j || grant_i) && livre_idx == SW'(i)) begin
          ativo[i]   <= 1'b1;
          sentido[i] <= grant_j;
          x_r[i]     <= grant_j ? bus.x_jogador : bus.x_inimigo;
          y_r[i]     <= grant_j ? y_spawn_j : y_spawn_i;
        end
      end
    end
  end

  assign bus.ack_jogador  = ack_j;
  assign bus.ack_inimigo  = ack_i;
  assign bus.ativo        = ativo;
  assign bus.sentido      = sentido;
  assign bus.dbg_contador = contador;
  assign bus.dbg_ponteiro = ponteiro;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign bus.x_tiros[10*g +: 10] = x_r[g];
    assign bus.y_tiros[10*g +: 10] = y_r[g];
  end
endmodule
